// File: rtl/cmd_uart_wrapper_if.sv
// Command-side bundle between the UART responder and the command processor.
// Latency: none (wires only).
// Backpressure: none; cmd_rdy is a level held until clr_cmd_rdy, trmt is ignored while tx is busy.
interface cmd_uart_wrapper_if;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        trmt;
    logic        tx_done;

    modport master (
        input  cmd, cmd_rdy, tx_done,
        output clr_cmd_rdy, resp, trmt
    );

    modport slave (
        output cmd, cmd_rdy, tx_done,
        input  clr_cmd_rdy, resp, trmt
    );
endinterface

// File: rtl/cmd_uart_wrapper.sv
// UART 8N1 responder: assembles two received bytes (high first) into a 16-bit command, sends a 1-byte response.
// Latency: cmd_rdy ~9.5 bit periods + 3 clk after the second start edge; TX start bit 1 clk after trmt.
// Backpressure: none; a new command overwrites cmd, trmt while transmitting is dropped.
module cmd_uart_wrapper #(
    parameter int BAUD_DIV = 2604
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RX,
    output logic              TX,
    cmd_uart_wrapper_if.slave host
);

    localparam int CNT_W = $clog2(BAUD_DIV + 1);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(BAUD_DIV / 2);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(BAUD_DIV);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;
    typedef enum logic {ASM_HIGH, ASM_LOW} asm_state_t;
    typedef enum logic {TX_IDLE, TX_XMIT} tx_state_t;

    // ---------------- RX synchroniser ----------------
    logic rx_meta, rx_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
        end
    end

    // ---------------- RX FSM ----------------
    rx_state_t        rx_state, rx_nxt;
    logic [CNT_W-1:0] rx_baud;
    logic [3:0]       rx_bits;
    logic [7:0]       rx_shift;
    logic             rx_start, rx_tick, rx_rdy;
    logic [7:0]       rx_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state <= RX_IDLE;
        else        rx_state <= rx_nxt;
    end

    always_comb begin
        rx_nxt   = rx_state;
        rx_start = 1'b0;
        rx_tick  = 1'b0;
        rx_rdy   = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (!rx_sync) begin
                    rx_start = 1'b1;
                    rx_nxt   = RX_RECV;
                end
            end
            RX_RECV: begin
                if (rx_baud == CNT_ONE) begin
                    rx_tick = 1'b1;
                    if (rx_bits == 4'd9) begin
                        rx_rdy = 1'b1;
                        rx_nxt = RX_IDLE;
                    end
                end
            end
            default: rx_nxt = RX_IDLE;
        endcase
    end

    // Only the data bits are kept: the start bit falls off the end and the stop sample is never stored.
    assign rx_byte = rx_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_baud  <= '0;
            rx_bits  <= '0;
            rx_shift <= '1;
        end else if (rx_start) begin
            rx_baud <= HALF_BIT;
            rx_bits <= '0;
        end else if (rx_tick) begin
            if (!rx_rdy) rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_bits <= rx_bits + 4'd1;
            rx_baud <= FULL_BIT;
        end else if (rx_state == RX_RECV) begin
            rx_baud <= rx_baud - CNT_ONE;
        end
    end

    // ---------------- Byte assembly ----------------
    asm_state_t  asm_state, asm_nxt;
    logic [7:0]  high_byte;
    logic [15:0] cmd_q;
    logic        cmd_rdy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) asm_state <= ASM_HIGH;
        else        asm_state <= asm_nxt;
    end

    always_comb begin
        asm_nxt = asm_state;
        if (rx_rdy) asm_nxt = (asm_state == ASM_HIGH) ? ASM_LOW : ASM_HIGH;
    end

    // Setting cmd_rdy takes priority over a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_byte <= '0;
            cmd_q     <= '0;
            cmd_rdy_q <= 1'b0;
        end else if (rx_rdy && asm_state == ASM_HIGH) begin
            high_byte <= rx_byte;
            cmd_rdy_q <= 1'b0;
        end else if (rx_rdy && asm_state == ASM_LOW) begin
            cmd_q     <= {high_byte, rx_byte};
            cmd_rdy_q <= 1'b1;
        end else if (host.clr_cmd_rdy) begin
            cmd_rdy_q <= 1'b0;
        end
    end

    assign host.cmd     = cmd_q;
    assign host.cmd_rdy = cmd_rdy_q;

    // ---------------- TX FSM ----------------
    tx_state_t        tx_state, tx_nxt;
    logic [CNT_W-1:0] tx_baud;
    logic [3:0]       tx_bits;
    logic [9:0]       tx_shift;
    logic             tx_load, tx_tick, tx_finish;
    logic             tx_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_state <= TX_IDLE;
        else        tx_state <= tx_nxt;
    end

    always_comb begin
        tx_nxt    = tx_state;
        tx_load   = 1'b0;
        tx_tick   = 1'b0;
        tx_finish = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (host.trmt) begin
                    tx_load = 1'b1;
                    tx_nxt  = TX_XMIT;
                end
            end
            TX_XMIT: begin
                if (tx_baud == CNT_ONE) begin
                    tx_tick = 1'b1;
                    if (tx_bits == 4'd9) begin
                        tx_finish = 1'b1;
                        tx_nxt    = TX_IDLE;
                    end
                end
            end
            default: tx_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift  <= '1;
            tx_baud   <= '0;
            tx_bits   <= '0;
            tx_done_q <= 1'b0;
        end else if (tx_load) begin
            tx_shift  <= {1'b1, host.resp, 1'b0};
            tx_baud   <= FULL_BIT;
            tx_bits   <= '0;
            tx_done_q <= 1'b0;
        end else if (tx_tick) begin
            tx_shift <= {1'b1, tx_shift[9:1]};
            tx_baud  <= FULL_BIT;
            tx_bits  <= tx_bits + 4'd1;
            if (tx_finish) tx_done_q <= 1'b1;
        end else if (tx_state == TX_XMIT) begin
            tx_baud <= tx_baud - CNT_ONE;
        end
    end

    assign TX           = tx_shift[0];
    assign host.tx_done = tx_done_q;

endmodule

// File: tb/tb_cmd_uart_wrapper.sv
// Directed bench for cmd_uart_wrapper at BAUD_DIV = 16: command assembly, clear/set collision,
// response framing, full duplex, framing error, and mid-frame reset.
module tb_cmd_uart_wrapper;

    localparam int BD = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic RX = 1'b1;
    logic TX;

    int n_cmp = 0;
    int n_err = 0;
    int lat;

    cmd_uart_wrapper_if u_if ();

    cmd_uart_wrapper #(.BAUD_DIV(BD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .RX    (RX),
        .TX    (TX),
        .host  (u_if)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Call at a negedge; drives one 8N1 frame, LSB first, BD clocks per bit.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        RX = 1'b0;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (BD) @(negedge clk);
        end
        RX = stop;
        repeat (BD) @(negedge clk);
        RX = 1'b1;
    endtask

    // Call at a negedge; pulses trmt and checks every bit boundary of the frame.
    task automatic tx_frame_check(input logic [7:0] b, input logic poke);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        u_if.resp = b;
        u_if.trmt = 1'b1;
        @(negedge clk);
        u_if.trmt = 1'b0;
        for (int j = 0; j < 10; j++) begin
            for (int c = 0; c < BD; c++) begin
                if (c == 0 || c == BD - 1) chk1($sformatf("tx_bit%0d_c%0d", j, c), TX, f[j]);
                if (j == 0 && c == 0) chk1("tx_done_start", u_if.tx_done, 1'b0);
                if (j == 9 && c == BD - 1) chk1("tx_done_last", u_if.tx_done, 1'b0);
                if (poke && j == 4 && c == 3) begin
                    u_if.resp = 8'h0F;
                    u_if.trmt = 1'b1;
                end
                if (poke && j == 4 && c == 4) u_if.trmt = 1'b0;
                @(negedge clk);
            end
        end
        chk1("tx_done_end", u_if.tx_done, 1'b1);
        chk1("tx_idle_end", TX, 1'b1);
    endtask

    task automatic pulse_clr();
        u_if.clr_cmd_rdy = 1'b1;
        @(negedge clk);
        u_if.clr_cmd_rdy = 1'b0;
    endtask

    initial begin
        u_if.clr_cmd_rdy = 1'b0;
        u_if.resp        = 8'h00;
        u_if.trmt        = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk1 ("rst_tx",      TX,           1'b1);
        chk16("rst_cmd",     u_if.cmd,     16'h0000);
        chk1 ("rst_cmd_rdy", u_if.cmd_rdy, 1'b0);
        chk1 ("rst_tx_done", u_if.tx_done, 1'b0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Single command 0x4004 with latency bound on the second byte
        send_byte(8'h40, 1'b1);
        chk1("rdy_after_first", u_if.cmd_rdy, 1'b0);
        lat = 0;
        fork
            send_byte(8'h04, 1'b1);
            begin
                while (!u_if.cmd_rdy && lat < 300) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
            end
        join
        chk1 ("cmd_rdy_latency", (lat >= 150 && lat <= 9 * BD + 8 + 3), 1'b1);
        chk1 ("cmd_rdy_single",  u_if.cmd_rdy, 1'b1);
        chk16("cmd_single",      u_if.cmd,     16'h4004);

        // Clear, then clear colliding with set
        pulse_clr();
        chk1 ("clr_rdy",  u_if.cmd_rdy, 1'b0);
        chk16("clr_cmd",  u_if.cmd,     16'h4004);
        send_byte(8'h20, 1'b1);
        fork
            send_byte(8'h02, 1'b1);
            begin
                repeat (9 * BD + 10) @(posedge clk);
                @(negedge clk);
                u_if.clr_cmd_rdy = 1'b1;
                @(negedge clk);
                u_if.clr_cmd_rdy = 1'b0;
            end
        join
        chk1 ("collide_rdy", u_if.cmd_rdy, 1'b1);
        chk16("collide_cmd", u_if.cmd,     16'h2002);

        // Response 0xA5 with an ignored second trmt mid-frame
        repeat (3) @(negedge clk);
        tx_frame_check(8'hA5, 1'b1);
        repeat (BD) @(negedge clk);
        chk1("tx_idle_after", TX, 1'b1);

        // Full duplex: command 0x6006 while sending 0xA5
        pulse_clr();
        fork
            begin
                send_byte(8'h60, 1'b1);
                send_byte(8'h06, 1'b1);
            end
            tx_frame_check(8'hA5, 1'b0);
        join
        @(negedge clk);
        chk1 ("duplex_rdy", u_if.cmd_rdy, 1'b1);
        chk16("duplex_cmd", u_if.cmd,     16'h6006);

        // Framing error on first byte, second byte immediately after
        pulse_clr();
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b1);
        repeat (2) @(negedge clk);
        chk1 ("frame_err_rdy", u_if.cmd_rdy, 1'b1);
        chk16("frame_err_cmd", u_if.cmd,     16'h1234);

        // Reset after a lone first byte and mid TX frame
        repeat (BD) @(negedge clk);
        send_byte(8'h77, 1'b1);
        u_if.resp = 8'hA5;
        u_if.trmt = 1'b1;
        @(negedge clk);
        u_if.trmt = 1'b0;
        repeat (39) @(negedge clk);
        chk1("pre_rst_tx_low", TX, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk1 ("mid_rst_tx",      TX,           1'b1);
        chk1 ("mid_rst_cmd_rdy", u_if.cmd_rdy, 1'b0);
        chk16("mid_rst_cmd",     u_if.cmd,     16'h0000);
        chk1 ("mid_rst_tx_done", u_if.tx_done, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        send_byte(8'hAB, 1'b1);
        chk1("post_rst_first", u_if.cmd_rdy, 1'b0);
        send_byte(8'hCD, 1'b1);
        repeat (2) @(negedge clk);
        chk1 ("post_rst_rdy", u_if.cmd_rdy, 1'b1);
        chk16("post_rst_cmd", u_if.cmd,     16'hABCD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cmd_uart_wrapper.md
# cmd_uart_wrapper

Responder end of the remote command link: it receives the two-byte commands that the remote command sender transmits over UART (8N1, high byte first) and presents them as one 16-bit command to the command processor. It also serialises a one-byte response (0xA5 = positive acknowledge) back over TX. It sits between the KnightsTour top-level RX/TX pins and the command-processing state machine. UART RX and TX are implemented inside this block.

## Interface
- BAUD_DIV, 2604, clocks per bit (19200 baud at 50 MHz); must be even and ≥ 8
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- RX  in  1  serial input from remote, idle high, asynchronous to clk
- TX  out  1  serial output to remote, idle high
- cmd  out  16  assembled command {first byte, second byte}
- cmd_rdy  out  1  level; a complete command is held on cmd
- clr_cmd_rdy  in  1  single-cycle pulse from consumer; clears cmd_rdy
- resp  in  8  response byte to send
- trmt  in  1  single-cycle pulse; starts transmitting resp
- tx_done  out  1  level; last response fully sent, including the stop bit

## Operation
- RX is passed through a 2-flop synchroniser with both flops preset to 1 on reset. All RX logic uses the synchronised value.
- RX FSM has states IDLE and RECV.
  - IDLE -> RECV when the synchronised RX is 0. The baud counter is loaded with BAUD_DIV/2 and the bit count is cleared.
  - In RECV, each time the baud counter expires: sample RX into a 10-bit shift register (LSB first), increment the bit count, and reload the counter with BAUD_DIV.
  - On the 10th sample (start, 8 data, stop): return to IDLE and pulse rx_rdy internally for one cycle with byte = data[7:0].
  - The stop-bit value is ignored. A framing error still delivers the byte.
- Byte-assembly FSM has states HIGH and LOW.
  - HIGH: on rx_rdy, store the byte in the high register, clear cmd_rdy, and go to LOW.
  - LOW: on rx_rdy, set cmd_rdy and go to HIGH. cmd = {high register, current byte}, and cmd is stable while cmd_rdy = 1.
  - If clr_cmd_rdy and the setting of cmd_rdy occur in the same cycle, the set wins.
  - clr_cmd_rdy in any state clears cmd_rdy and does not change the byte-assembly state.
- TX FSM has states IDLE and XMIT.
  - trmt in IDLE loads {1, resp, 0} into a 10-bit shift register, clears tx_done, and goes to XMIT.
  - TX = shift[0]. The register shifts right, filling with 1, every BAUD_DIV clocks.
  - After 10 bit periods: set tx_done and return to IDLE.
  - trmt while in XMIT is ignored; the frame in progress is not disturbed.
- RX and TX run fully independently, so full duplex is allowed.
- Reset at any point aborts any frame in progress and returns all FSMs to IDLE/HIGH. No partial command survives reset.

## Timing
- Reset values: TX = 1, cmd = 0x0000, cmd_rdy = 0, tx_done = 0. Internal: high register = 0, both shift registers all 1s.
- Data bits are sampled at mid-bit: at 0.5, 1.5, …, 9.5 bit periods after the start edge, plus 2 clk of synchroniser delay.
- cmd_rdy rises 1 clk after the internal rx_rdy of the second byte, which is about 9.5·BAUD_DIV + 3 clk after the falling edge of that byte's start bit.
- cmd is a registered output and changes only in the cycle cmd_rdy is set.
- TX timing after trmt:
  - The start bit appears on TX 1 clk after trmt.
  - Each bit is held exactly BAUD_DIV clk.
  - tx_done rises exactly 10·BAUD_DIV clk after TX went low.
- Back-to-back frames:
  - RX accepts a new start bit on the first cycle after returning to IDLE.
  - TX accepts trmt in the cycle after tx_done rises.
- No inter-byte timeout: a lone first byte waits in LOW indefinitely.

## Test plan
- Use BAUD_DIV = 16 throughout.
- Single command: send 0x40 then 0x04 -> cmd = 0x4004 and cmd_rdy = 1 within 9·16 + 8 + 3 clk of the second start edge. cmd_rdy must stay 0 after the first byte.
- Clear and set collision:
  - Pulse clr_cmd_rdy -> cmd_rdy = 0 next clk, cmd still 0x4004.
  - Send 0x2002 with clr_cmd_rdy pulsed in the same cycle that cmd_rdy would be set -> cmd_rdy = 1, cmd = 0x2002.
- Response: assert trmt with resp = 0xA5.
  - TX carries 0,1,0,1,0,0,1,0,1,1, each bit exactly 16 clk.
  - tx_done = 0 during the frame and 1 after 160 clk.
  - A second trmt mid-frame has no effect.
- Full duplex: send command 0x6006 while transmitting 0xA5 -> both complete correctly with unchanged timing.
- Framing error / back-to-back: first byte 0x12 with stop bit = 0, then 0x34 immediately -> cmd = 0x1234 and cmd_rdy = 1.
- Reset mid-frame: assert rst_n low after the first byte and midway through a TX frame -> TX = 1, cmd_rdy = 0, cmd = 0, tx_done = 0. The next two bytes 0xAB, 0xCD yield cmd = 0xABCD.
